demortl_dma_chunk_engine: RTL and testbench

- Parametrised successor of the fixed 64-bit demo accelerator core.
- Reads `conf_info_tx_size` beats from DMA memory and splits the transfer into bursts of at most CHUNK_BEATS.
- Each chunk goes into a local buffer, receives a per-lane transform selected by `conf_info_mode`, and is written back to the region directly after the input.
- Sits between the ESP-style DMA ctrl/chnl interfaces and the accelerator socket; pulses `acc_done` when finished.

---
 rtl/demortl_dma_chunk_engine.sv | 218 +++++++++++++++++++++
 tb/tb_demortl_dma_chunk_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demortl_dma_chunk_engine.sv
// Chunked DMA engine: reads tx_size beats in bursts of up to CHUNK_BEATS,
// transforms each beat per lane and writes the result directly after the input region.
module demortl_dma_chunk_engine #(
  parameter int unsigned DMA_BUS_WIDTH = 64,
  parameter int unsigned CHUNK_BEATS   = 16,
  parameter int unsigned LANE_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              conf_info_tx_size,
  input  logic [31:0]              conf_info_rx_size,
  input  logic [1:0]               conf_info_mode,
  input  logic                     conf_done,
  output logic                     dma_read_ctrl_valid,
  input  logic                     dma_read_ctrl_ready,
  output logic [31:0]              dma_read_ctrl_data_index,
  output logic [31:0]              dma_read_ctrl_data_length,
  output logic [2:0]               dma_read_ctrl_data_size,
  input  logic                     dma_read_chnl_valid,
  output logic                     dma_read_chnl_ready,
  input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
  output logic                     dma_write_ctrl_valid,
  input  logic                     dma_write_ctrl_ready,
  output logic [31:0]              dma_write_ctrl_data_index,
  output logic [31:0]              dma_write_ctrl_data_length,
  output logic [2:0]               dma_write_ctrl_data_size,
  output logic                     dma_write_chnl_valid,
  input  logic                     dma_write_chnl_ready,
  output logic [DMA_BUS_WIDTH-1:0] dma_write_chnl_data,
  output logic                     acc_done,
  output logic [31:0]              debug
);

  localparam int unsigned IDX_W = $clog2(CHUNK_BEATS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned LANES = DMA_BUS_WIDTH / LANE_WIDTH;
  localparam logic [2:0]  DATA_SIZE = 3'($clog2(DMA_BUS_WIDTH / 8));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    WR_REQ  = 3'd4,
    WR_DATA = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t                   state;
  logic [31:0]              tx_size;
  logic [31:0]              rx_size;
  logic [1:0]               mode;
  logic [31:0]              offset;
  logic [31:0]              len;
  logic [CNT_W-1:0]         wptr;
  logic [CNT_W-1:0]         rptr;
  logic [CNT_W-1:0]         rptr_next;
  logic [3:0]               err;
  logic [23:0]              chunks_done;
  logic [31:0]              offset_next;
  logic                     rd_fire;
  logic                     wr_fire;
  logic [DMA_BUS_WIDTH-1:0] buffer [CHUNK_BEATS];

  function automatic logic [DMA_BUS_WIDTH-1:0] transform(input logic [1:0] m,
                                                         input logic [DMA_BUS_WIDTH-1:0] d);
    logic [DMA_BUS_WIDTH-1:0] r;
    r = d;
    case (m)
      2'd1: r = ~d;
      2'd2: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          r[l*LANE_WIDTH +: LANE_WIDTH] = d[l*LANE_WIDTH +: LANE_WIDTH] + LANE_WIDTH'(1);
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] chunk_len(input logic [31:0] total, input logic [31:0] off);
    logic [31:0] rem;
    rem = total - off;
    return (rem < 32'(CHUNK_BEATS)) ? rem : 32'(CHUNK_BEATS);
  endfunction

  assign dma_read_ctrl_data_size  = DATA_SIZE;
  assign dma_write_ctrl_data_size = DATA_SIZE;
  assign debug       = {1'b0, state, err, chunks_done};
  assign rd_fire     = (state == RD_DATA) && dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_fire     = (state == WR_DATA) && dma_write_chnl_valid && dma_write_chnl_ready;
  assign offset_next = offset + len;
  assign rptr_next   = rptr + CNT_W'(1);

  // Local chunk buffer holds already-transformed beats.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      buffer[wptr[IDX_W-1:0]] <= transform(mode, dma_read_chnl_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      tx_size                    <= '0;
      rx_size                    <= '0;
      mode                       <= '0;
      offset                     <= '0;
      len                        <= '0;
      wptr                       <= '0;
      rptr                       <= '0;
      err                        <= '0;
      chunks_done                <= '0;
      dma_read_ctrl_valid        <= 1'b0;
      dma_read_ctrl_data_index   <= '0;
      dma_read_ctrl_data_length  <= '0;
      dma_read_chnl_ready        <= 1'b0;
      dma_write_ctrl_valid       <= 1'b0;
      dma_write_ctrl_data_index  <= '0;
      dma_write_ctrl_data_length <= '0;
      dma_write_chnl_valid       <= 1'b0;
      dma_write_chnl_data        <= '0;
      acc_done                   <= 1'b0;
    end else begin
      acc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (conf_done) begin
            tx_size     <= conf_info_tx_size;
            rx_size     <= conf_info_rx_size;
            mode        <= conf_info_mode;
            offset      <= '0;
            chunks_done <= '0;
            err         <= '0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (rx_size != tx_size) begin
            err      <= 4'd1;
            acc_done <= 1'b1;
            state    <= ERR;
          end else if (mode == 2'd3) begin
            err      <= 4'd2;
            acc_done <= 1'b1;
            state    <= ERR;
          end else if (tx_size == 32'd0) begin
            acc_done <= 1'b1;
            state    <= DONE;
          end else begin
            dma_read_ctrl_valid       <= 1'b1;
            dma_read_ctrl_data_index  <= offset;
            dma_read_ctrl_data_length <= chunk_len(tx_size, offset);
            len                       <= chunk_len(tx_size, offset);
            state                     <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (dma_read_ctrl_ready) begin
            dma_read_ctrl_valid <= 1'b0;
            dma_read_chnl_ready <= 1'b1;
            wptr                <= '0;
            state               <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_fire) begin
            wptr <= wptr + CNT_W'(1);
            if (32'(wptr) == len - 32'd1) begin
              dma_read_chnl_ready        <= 1'b0;
              dma_write_ctrl_valid       <= 1'b1;
              dma_write_ctrl_data_index  <= tx_size + offset;
              dma_write_ctrl_data_length <= len;
              state                      <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (dma_write_ctrl_ready) begin
            dma_write_ctrl_valid <= 1'b0;
            dma_write_chnl_valid <= 1'b1;
            dma_write_chnl_data  <= buffer[0];
            rptr                 <= '0;
            state                <= WR_DATA;
          end
        end
        WR_DATA: begin
          // Data register only advances on a handshake, so it holds under backpressure.
          if (wr_fire) begin
            rptr <= rptr_next;
            if (32'(rptr) == len - 32'd1) begin
              dma_write_chnl_valid <= 1'b0;
              offset               <= offset_next;
              chunks_done          <= chunks_done + 24'd1;
              if (offset_next == tx_size) begin
                acc_done <= 1'b1;
                state    <= DONE;
              end else begin
                dma_read_ctrl_valid       <= 1'b1;
                dma_read_ctrl_data_index  <= offset_next;
                dma_read_ctrl_data_length <= chunk_len(tx_size, offset_next);
                len                       <= chunk_len(tx_size, offset_next);
                state                     <= RD_REQ;
              end
            end else begin
              dma_write_chnl_data <= buffer[rptr_next[IDX_W-1:0]];
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demortl_dma_chunk_engine.sv
// Randomized bench for demortl_dma_chunk_engine: a DMA memory model with optional
// backpressure on all four interfaces, checked against a chunking/transform reference.
module tb_demortl_dma_chunk_engine;

  localparam int unsigned DW     = 64;
  localparam int unsigned CB     = 16;
  localparam int          BUDGET = 6000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   conf_info_tx_size;
  logic [31:0]   conf_info_rx_size;
  logic [1:0]    conf_info_mode;
  logic          conf_done;
  logic          dma_read_ctrl_valid;
  logic          dma_read_ctrl_ready;
  logic [31:0]   dma_read_ctrl_data_index;
  logic [31:0]   dma_read_ctrl_data_length;
  logic [2:0]    dma_read_ctrl_data_size;
  logic          dma_read_chnl_valid;
  logic          dma_read_chnl_ready;
  logic [DW-1:0] dma_read_chnl_data;
  logic          dma_write_ctrl_valid;
  logic          dma_write_ctrl_ready;
  logic [31:0]   dma_write_ctrl_data_index;
  logic [31:0]   dma_write_ctrl_data_length;
  logic [2:0]    dma_write_ctrl_data_size;
  logic          dma_write_chnl_valid;
  logic          dma_write_chnl_ready;
  logic [DW-1:0] dma_write_chnl_data;
  logic          acc_done;
  logic [31:0]   debug;

  demortl_dma_chunk_engine #(.DMA_BUS_WIDTH(DW), .CHUNK_BEATS(CB), .LANE_WIDTH(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .conf_info_tx_size          (conf_info_tx_size),
    .conf_info_rx_size          (conf_info_rx_size),
    .conf_info_mode             (conf_info_mode),
    .conf_done                  (conf_done),
    .dma_read_ctrl_valid        (dma_read_ctrl_valid),
    .dma_read_ctrl_ready        (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
    .dma_read_chnl_valid        (dma_read_chnl_valid),
    .dma_read_chnl_ready        (dma_read_chnl_ready),
    .dma_read_chnl_data         (dma_read_chnl_data),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .acc_done                   (acc_done),
    .debug                      (debug)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] src_mem [256];
  logic [DW-1:0] out_mem [512];
  int            wcount  [512];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference transform written directly from the mode definitions.
  function automatic logic [63:0] ref_xform(input int md, input logic [63:0] d);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = d[63:32];
    lo = d[31:0];
    if (md == 1) return ~d;
    if (md == 2) return {hi + 32'd1, lo + 32'd1};
    return d;
  endfunction

  task automatic idle_inputs();
    conf_done            = 1'b0;
    dma_read_ctrl_ready  = 1'b0;
    dma_read_chnl_valid  = 1'b0;
    dma_read_chnl_data   = '0;
    dma_write_ctrl_ready = 1'b0;
    dma_write_chnl_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".rc_valid"}, 64'(dma_read_ctrl_valid), 64'd0);
    chk({name, ".rc_fields"}, {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, 64'd0);
    chk({name, ".rd_ready"}, 64'(dma_read_chnl_ready), 64'd0);
    chk({name, ".wc_valid"}, 64'(dma_write_ctrl_valid), 64'd0);
    chk({name, ".wc_fields"}, {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, 64'd0);
    chk({name, ".wd_valid"}, 64'(dma_write_chnl_valid), 64'd0);
    chk({name, ".acc_done"}, 64'(acc_done), 64'd0);
    chk({name, ".debug"}, 64'(debug), 64'd0);
  endtask

  task automatic run_job(input string name, input int tx, input int rx, input int md,
                         input bit bp, input int abort_beat);
    int exp_rd_idx[$], exp_rd_len[$], exp_wr_idx[$], exp_wr_len[$];
    int got_rd_idx[$], got_rd_len[$], got_wr_idx[$], got_wr_len[$];
    int cyc, done_cnt, first_done, any_valid, beats_out;
    int rd_ptr, rd_rem, wr_ptr, wr_rem;
    bit rc_stall, wc_stall, wd_stall;
    logic [63:0] rc_prev, wc_prev, wd_prev;
    bit good;

    good = (tx == rx) && (md != 3);
    if (good) begin
      for (int off = 0; off < tx; off += CB) begin
        int n;
        n = (tx - off < CB) ? tx - off : CB;
        exp_rd_idx.push_back(off);      exp_rd_len.push_back(n);
        exp_wr_idx.push_back(tx + off); exp_wr_len.push_back(n);
      end
    end
    for (int i = 0; i < 512; i++) wcount[i] = 0;

    @(negedge clk);
    conf_info_tx_size = 32'(tx);
    conf_info_rx_size = 32'(rx);
    conf_info_mode    = 2'(md);
    conf_done         = 1'b1;
    @(negedge clk);
    conf_done = 1'b0;

    cyc = 0; done_cnt = 0; first_done = -1; any_valid = 0; beats_out = 0;
    rd_ptr = 0; rd_rem = 0; wr_ptr = 0; wr_rem = 0;
    rc_stall = 0; wc_stall = 0; wd_stall = 0;
    rc_prev = '0; wc_prev = '0; wd_prev = '0;

    while (cyc < BUDGET) begin
      if (acc_done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      if (dma_read_ctrl_valid || dma_read_chnl_ready || dma_write_ctrl_valid || dma_write_chnl_valid)
        any_valid = 1;
      if (rc_stall) begin
        chk({name, ".rc_hold_v"}, 64'(dma_read_ctrl_valid), 64'd1);
        chk({name, ".rc_hold"}, {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, rc_prev);
      end
      if (wc_stall) begin
        chk({name, ".wc_hold_v"}, 64'(dma_write_ctrl_valid), 64'd1);
        chk({name, ".wc_hold"}, {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, wc_prev);
      end
      if (wd_stall) begin
        chk({name, ".wd_hold_v"}, 64'(dma_write_chnl_valid), 64'd1);
        chk({name, ".wd_hold"}, dma_write_chnl_data, wd_prev);
      end

      // Read data channel from the memory model.
      dma_read_chnl_data = src_mem[rd_ptr[7:0]];
      if (rd_rem > 0) begin
        dma_read_chnl_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin
          rd_ptr++;
          rd_rem--;
        end
      end else begin
        dma_read_chnl_valid = 1'b0;
      end

      dma_read_ctrl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
        got_rd_idx.push_back(int'(dma_read_ctrl_data_index));
        got_rd_len.push_back(int'(dma_read_ctrl_data_length));
        rd_ptr = int'(dma_read_ctrl_data_index);
        rd_rem = int'(dma_read_ctrl_data_length);
      end

      dma_write_ctrl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
        got_wr_idx.push_back(int'(dma_write_ctrl_data_index));
        got_wr_len.push_back(int'(dma_write_ctrl_data_length));
        wr_ptr = int'(dma_write_ctrl_data_index);
        wr_rem = int'(dma_write_ctrl_data_length);
      end

      dma_write_chnl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dma_write_chnl_valid && dma_write_chnl_ready) begin
        beats_out++;
        if (wr_rem > 0 && wr_ptr < 512) begin
          out_mem[wr_ptr] = dma_write_chnl_data;
          wcount[wr_ptr]++;
          wr_ptr++;
          wr_rem--;
        end
      end

      rc_stall = dma_read_ctrl_valid && !dma_read_ctrl_ready;
      rc_prev  = {dma_read_ctrl_data_index, dma_read_ctrl_data_length};
      wc_stall = dma_write_ctrl_valid && !dma_write_ctrl_ready;
      wc_prev  = {dma_write_ctrl_data_index, dma_write_ctrl_data_length};
      wd_stall = dma_write_chnl_valid && !dma_write_chnl_ready;
      wd_prev  = dma_write_chnl_data;

      if (abort_beat > 0 && beats_out >= abort_beat) begin
        rst = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      if (first_done >= 0 && cyc >= first_done + 3) break;
    end
    idle_inputs();

    if (abort_beat > 0) begin
      chk({name, ".reached_abort"}, 64'(beats_out), 64'(abort_beat));
      @(negedge clk);
      chk_all_zero({name, ".after_rst"});
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (acc_done) done_cnt++;
      end
      chk({name, ".no_done"}, 64'(done_cnt), 64'd0);
      chk({name, ".idle_debug"}, 64'(debug), 64'd0);
      return;
    end

    chk({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
    chk({name, ".rd_reqs"}, 64'(got_rd_idx.size()), 64'(exp_rd_idx.size()));
    chk({name, ".wr_reqs"}, 64'(got_wr_idx.size()), 64'(exp_wr_idx.size()));
    for (int i = 0; i < exp_rd_idx.size() && i < got_rd_idx.size(); i++)
      chk($sformatf("%s.rd_req%0d", name, i), {32'(got_rd_idx[i]), 32'(got_rd_len[i])},
          {32'(exp_rd_idx[i]), 32'(exp_rd_len[i])});
    for (int i = 0; i < exp_wr_idx.size() && i < got_wr_idx.size(); i++)
      chk($sformatf("%s.wr_req%0d", name, i), {32'(got_wr_idx[i]), 32'(got_wr_len[i])},
          {32'(exp_wr_idx[i]), 32'(exp_wr_len[i])});
    chk({name, ".beats_out"}, 64'(beats_out), good ? 64'(tx) : 64'd0);
    if (good) begin
      for (int i = 0; i < tx; i++) begin
        chk($sformatf("%s.wcount%0d", name, i), 64'(wcount[tx + i]), 64'd1);
        chk($sformatf("%s.data%0d", name, i), out_mem[tx + i], ref_xform(md, src_mem[i]));
      end
    end
    if (!good || tx == 0) begin
      chk({name, ".done_latency"}, 64'(first_done), 64'd1);
      chk({name, ".no_valid"}, 64'(any_valid), 64'd0);
    end
    chk({name, ".dbg_state"}, 64'(debug[31:28]), 64'd0);
    chk({name, ".dbg_err"}, 64'(debug[27:24]), (tx != rx) ? 64'd1 : (md == 3) ? 64'd2 : 64'd0);
    chk({name, ".dbg_chunks"}, 64'(debug[23:0]), good ? 64'((tx + CB - 1) / CB) : 64'd0);
  endtask

  initial begin
    conf_info_tx_size = '0;
    conf_info_rx_size = '0;
    conf_info_mode    = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("data_size", {dma_read_ctrl_data_size, dma_write_ctrl_data_size}, {3'd3, 3'd3});
    rst = 1'b0;

    for (int i = 0; i < 256; i++) src_mem[i] = 64'(i);
    run_job("copy8", 8, 8, 0, 1'b0, 0);

    for (int i = 0; i < 256; i++) src_mem[i] = 64'hFFFF_FFFF_0000_0001;
    run_job("tail37", 37, 37, 2, 1'b0, 0);
    chk("tail37.lane_value", out_mem[37 + 36], 64'h0000_0000_0000_0002);

    for (int i = 0; i < 256; i++) src_mem[i] = {$urandom, $urandom};
    run_job("bp_inv", 37, 37, 1, 1'b1, 0);
    run_job("bp_add", 20, 20, 2, 1'b1, 0);
    run_job("bp_copy", 16, 16, 0, 1'b1, 0);

    run_job("size_err", 8, 9, 0, 1'b0, 0);
    run_job("mode_err", 8, 8, 3, 1'b0, 0);
    run_job("zero", 0, 0, 0, 1'b0, 0);

    run_job("abort", 40, 40, 0, 1'b0, 20);
    run_job("post", 4, 4, 1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
